// File: rtl/vc_pkg.sv
// Shared definitions for the QSPI line-transfer arbiter: state encoding,
// requester indices and the line-tag width derivation.
package vc_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_GAP  = 2'd2;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;
  localparam int REQ_X = 2;
  localparam int NREQ  = 3;

  // Line tag width: physical address minus the byte-in-line bits.
  function automatic int tag_width(input int pa, input int line_length);
    return pa - $clog2(line_length);
  endfunction

endpackage

// File: rtl/qspi_arb_pick.sv
// Combinational winner select for the QSPI arbiter. Returns a one-hot vector
// indexed by REQ_I / REQ_D / REQ_X. The aux port jumps the queue once the
// caller reports that the starvation limit has been reached.
module qspi_arb_pick
  import vc_pkg::*;
(
  input  logic            i_req,
  input  logic            d_req,
  input  logic            d_write,
  input  logic            x_req,
  input  logic            starve_hit,
  output logic [NREQ-1:0] win
);

  // Priority: starved aux, dcache push, dcache fill, icache, aux.
  always_comb begin
    win = '0;
    if (x_req && starve_hit) begin
      win[REQ_X] = 1'b1;
    end else if (d_req && d_write) begin
      win[REQ_D] = 1'b1;
    end else if (d_req) begin
      win[REQ_D] = 1'b1;
    end else if (i_req) begin
      win[REQ_I] = 1'b1;
    end else if (x_req) begin
      win[REQ_X] = 1'b1;
    end
  end

endmodule

// File: rtl/qspi_arb.sv
// QSPI line-transfer arbiter. Registers the grant and the transfer fields of
// the winning requester, holds them until qspi reports completion, then
// enforces a chip-select idle gap before the next arbitration.
//
// state    | meaning
// ARB_IDLE | no owner, arbitrate on every edge
// ARB_BUSY | owner holds the engine until q_done
// ARB_GAP  | forced CS idle; last gap edge doubles as an arbitration edge
module qspi_arb
  import vc_pkg::*;
#(
  parameter  int PA          = 24,
  parameter  int LINE_LENGTH = 4,
  parameter  int GAP         = 1,
  parameter  int STARVE_MAX  = 4,
  localparam int TW          = vc_pkg::tag_width(PA, LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic [1:0]    i_mem,
  output logic          i_gnt,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  input  logic [1:0]    d_mem,
  output logic          d_gnt,
  output logic          d_done,
  input  logic          x_req,
  input  logic          x_write,
  input  logic [TW-1:0] x_tag,
  input  logic [1:0]    x_mem,
  output logic          x_gnt,
  output logic          x_done,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [TW-1:0] q_paddr,
  output logic [1:0]    q_mem,
  input  logic          q_done,
  output logic          busy
);

  localparam logic [2:0] GAP_LOAD   = 3'(GAP - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]      state_q, state_d;
  logic [2:0]      gap_cnt_q, gap_cnt_d;
  logic [3:0]      starve_q, starve_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            q_req_q, q_req_d;
  logic            q_i_d_q, q_i_d_d;
  logic            q_write_q, q_write_d;
  logic [TW-1:0]   q_paddr_q, q_paddr_d;
  logic [1:0]      q_mem_q, q_mem_d;

  logic [NREQ-1:0] win;
  logic            starve_hit;
  logic            any_req;
  logic            arb_slot;

  assign starve_hit = (starve_q == STARVE_LIM);
  assign any_req    = i_req | d_req | x_req;
  assign arb_slot   = (state_q == ARB_IDLE) ||
                      ((state_q == ARB_GAP) && (gap_cnt_q == 3'd0));

  qspi_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .d_write    (d_write),
    .x_req      (x_req),
    .starve_hit (starve_hit),
    .win        (win)
  );

  // Next-state: grant on an arbitration slot, release on q_done, count the gap.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    starve_d  = starve_q;
    gnt_d     = gnt_q;
    q_req_d   = q_req_q;
    q_i_d_d   = q_i_d_q;
    q_write_d = q_write_q;
    q_paddr_d = q_paddr_q;
    q_mem_d   = q_mem_q;
    case (state_q)
      ARB_BUSY: begin
        if (q_done) begin
          gnt_d     = '0;
          q_req_d   = 1'b0;
          q_i_d_d   = 1'b0;
          q_write_d = 1'b0;
          gap_cnt_d = GAP_LOAD;
          state_d   = ARB_GAP;
        end
      end
      ARB_IDLE, ARB_GAP: begin
        if (!arb_slot) begin
          gap_cnt_d = gap_cnt_q - 3'd1;
        end else if (any_req) begin
          state_d = ARB_BUSY;
          gnt_d   = win;
          q_req_d = 1'b1;
          if (win[REQ_D]) begin
            q_i_d_d   = 1'b0;
            q_write_d = d_write;
            q_paddr_d = d_tag;
            q_mem_d   = d_mem;
          end else if (win[REQ_I]) begin
            q_i_d_d   = 1'b1;
            q_write_d = 1'b0;
            q_paddr_d = i_tag;
            q_mem_d   = i_mem;
          end else begin
            q_i_d_d   = 1'b0;
            q_write_d = x_write;
            q_paddr_d = x_tag;
            q_mem_d   = x_mem;
          end
          // A cache win while aux is waiting counts against aux; anything else clears.
          starve_d = (x_req && !win[REQ_X]) ? starve_q + 4'd1 : 4'd0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      gap_cnt_q <= 3'd0;
      starve_q  <= 4'd0;
      gnt_q     <= '0;
      q_req_q   <= 1'b0;
      q_i_d_q   <= 1'b0;
      q_write_q <= 1'b0;
      q_paddr_q <= '0;
      q_mem_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      starve_q  <= starve_d;
      gnt_q     <= gnt_d;
      q_req_q   <= q_req_d;
      q_i_d_q   <= q_i_d_d;
      q_write_q <= q_write_d;
      q_paddr_q <= q_paddr_d;
      q_mem_q   <= q_mem_d;
    end
  end

  assign i_gnt   = gnt_q[REQ_I];
  assign d_gnt   = gnt_q[REQ_D];
  assign x_gnt   = gnt_q[REQ_X];
  // Grants exist only in BUSY, so q_done elsewhere never reaches a done.
  assign i_done  = gnt_q[REQ_I] & q_done;
  assign d_done  = gnt_q[REQ_D] & q_done;
  assign x_done  = gnt_q[REQ_X] & q_done;
  assign q_req   = q_req_q;
  assign q_i_d   = q_i_d_q;
  assign q_write = q_write_q;
  assign q_paddr = q_paddr_q;
  assign q_mem   = q_mem_q;
  assign busy    = (state_q != ARB_IDLE);

endmodule
